// File: rtl/ov5640_capture_ctrl_if.sv
// ---------------------------------------------------------------------------
// ov5640_capture_ctrl_if
//   Pixel write bus from the capture sequencer to the frame-buffer writer.
//
//   Signals:
//     out_valid  pixel write strobe
//     out_data   RGB565 pixel
//     out_addr   linear frame address y*H_ACTIVE+x
//     out_sof    first pixel of the frame (x=0, y=0)
//     out_eol    last pixel of a line (x=H_ACTIVE-1)
//
//   Modports:
//     master  drives the bus (capture sequencer)
//     slave   consumes the bus (frame-buffer writer)
// ---------------------------------------------------------------------------
interface ov5640_capture_ctrl_if #(
    parameter int ADDR_W = 19
);
    logic              out_valid;
    logic [15:0]       out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_sof;
    logic              out_eol;

    modport master (
        output out_valid,
        output out_data,
        output out_addr,
        output out_sof,
        output out_eol
    );

    modport slave (
        input out_valid,
        input out_data,
        input out_addr,
        input out_sof,
        input out_eol
    );
endinterface

// File: rtl/ov5640_capture_ctrl.sv
// ---------------------------------------------------------------------------
// ov5640_capture_ctrl
//   Frame-capture sequencer between the OV5640 pixel assembler and the
//   frame-buffer writer. Ignores the first SKIP_FRAMES sensor frames after
//   reset, arms on cap_start, and passes whole frames only (capture always
//   begins on a vsync rising edge). Each accepted pixel carries a linear write
//   address; every frame is checked against H_ACTIVE x V_ACTIVE.
//
//   Optional feature (compile-time macro OV5640_CAP_TIMEOUT_EN):
//     watchdog that aborts a capture stuck for TIMEOUT_CYCLES pclk without
//     a vsync rising edge. Without the macro no watchdog exists.
//
//   Ports:
//     cmos_pclk   pixel clock, sole clock
//     rst         asynchronous active-high reset
//     cmos_vsync  sensor vsync (high = blanking)
//     cmos_href   sensor href
//     pix_valid   assembled pixel strobe (1 pclk after the data phase)
//     pix_data    assembled RGB565 pixel
//     cap_start   pulse: request capture
//     cap_mode    sampled with cap_start: 0 single frame, 1 continuous
//     cap_stop    pulse: end capture after the current frame
//     cap_busy    high while waiting for a frame or capturing
//     frame_done  one-cycle pulse: good frame completed
//     frame_err   one-cycle pulse: bad or aborted frame
//     frame_cnt   good frame counter, wraps 255->0
//     pix_out     pixel write bus (master side)
// ---------------------------------------------------------------------------
module ov5640_capture_ctrl #(
    parameter int H_ACTIVE       = 640,
    parameter int V_ACTIVE       = 480,
    parameter int SKIP_FRAMES    = 10,
    parameter int ADDR_W         = 19,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic        cmos_pclk,
    input  logic        rst,
    input  logic        cmos_vsync,
    input  logic        cmos_href,
    input  logic        pix_valid,
    input  logic [15:0] pix_data,
    input  logic        cap_start,
    input  logic        cap_mode,
    input  logic        cap_stop,
    output logic        cap_busy,
    output logic        frame_done,
    output logic        frame_err,
    output logic [7:0]  frame_cnt,
    ov5640_capture_ctrl_if.master pix_out
);
    localparam int XW = $clog2(H_ACTIVE + 1);
    localparam int YW = $clog2(V_ACTIVE + 1);
    localparam logic [XW-1:0]     H_X    = XW'(H_ACTIVE);
    localparam logic [YW-1:0]     V_Y    = YW'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] H_ADDR = ADDR_W'(H_ACTIVE);
    localparam logic [3:0]        SKIP_C = 4'(SKIP_FRAMES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic              vs_d1_reg;
    logic              href_d1_reg, href_d2_reg;
    logic [3:0]        skip_cnt_reg, skip_cnt_next;
    logic              mode_reg, mode_next;
    logic              stop_pend_reg, stop_pend_next;
    logic              err_reg, err_next;
    logic [XW-1:0]     x_reg, x_next;
    logic [YW-1:0]     y_reg, y_next;
    logic [ADDR_W-1:0] base_reg, base_next;

    logic              valid_reg, valid_next;
    logic [15:0]       data_reg, data_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic              sof_reg, sof_next;
    logic              eol_reg, eol_next;
    logic              done_reg, done_next;
    logic              ferr_reg, ferr_next;
    logic [7:0]        cnt_reg, cnt_next;

    logic vs_pos, line_end, skip_done, accept, stop_now, frame_good;

    // Frame boundary: vsync rising edge against its one-cycle-delayed copy.
    assign vs_pos    = cmos_vsync & ~vs_d1_reg;
    // Line end two pclk after href falls, i.e. after the last assembled pixel.
    assign line_end  = href_d2_reg & ~href_d1_reg;
    assign skip_done = (skip_cnt_reg == SKIP_C);
    assign accept    = (state_reg == CAPTURE) && pix_valid &&
                       (x_reg < H_X) && (y_reg < V_Y);
    assign stop_now  = stop_pend_reg | cap_stop;

`ifdef OV5640_CAP_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);
    logic [WDW-1:0] wd_reg, wd_next;
`endif

    always_comb begin
        state_next     = state_reg;
        skip_cnt_next  = skip_cnt_reg;
        mode_next      = mode_reg;
        stop_pend_next = stop_pend_reg;
        err_next       = err_reg;
        x_next         = x_reg;
        y_next         = y_reg;
        base_next      = base_reg;
        valid_next     = 1'b0;
        data_next      = data_reg;
        addr_next      = addr_reg;
        sof_next       = 1'b0;
        eol_next       = 1'b0;
        done_next      = 1'b0;
        ferr_next      = 1'b0;
        cnt_next       = cnt_reg;
        frame_good     = 1'b0;

        if (vs_pos && !skip_done) begin
            skip_cnt_next = skip_cnt_reg + 4'd1;
        end

        case (state_reg)
            IDLE: begin
                if (cap_start && !cap_stop) begin
                    state_next = WAIT_VS;
                    mode_next  = cap_mode;
                end
            end
            WAIT_VS: begin
                if (cap_stop) begin
                    state_next = IDLE;
                end else if (vs_pos && skip_done) begin
                    state_next = CAPTURE;
                    x_next     = '0;
                    y_next     = '0;
                    base_next  = '0;
                    err_next   = 1'b0;
                end
            end
            CAPTURE: begin
                if (accept) begin
                    valid_next = 1'b1;
                    data_next  = pix_data;
                    addr_next  = base_reg + ADDR_W'(x_reg);
                    sof_next   = (x_reg == '0) && (y_reg == '0);
                    eol_next   = (x_reg == H_X - XW'(1));
                end
                if (pix_valid && !accept) begin
                    err_next = 1'b1;
                end
                // x_next includes a pixel accepted this cycle so a coincident
                // line end sees the full line length.
                x_next = x_reg + XW'(accept);
                if (line_end && (x_next != '0)) begin
                    if (x_next != H_X) begin
                        err_next = 1'b1;
                    end
                    y_next    = y_reg + YW'(1);
                    base_next = base_reg + H_ADDR;
                    x_next    = '0;
                end
                if (cap_stop) begin
                    stop_pend_next = 1'b1;
                end
                // The line end above has already been folded into y_next.
                if (vs_pos) begin
                    frame_good = !err_next && (y_next == V_Y);
                    done_next  = frame_good;
                    ferr_next  = !frame_good;
                    cnt_next   = cnt_reg + 8'(frame_good);
                    x_next     = '0;
                    y_next     = '0;
                    base_next  = '0;
                    err_next   = 1'b0;
                    if (!(mode_reg && !stop_now)) begin
                        state_next     = IDLE;
                        stop_pend_next = 1'b0;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

`ifdef OV5640_CAP_TIMEOUT_EN
        wd_next = '0;
        if (state_reg != IDLE && !vs_pos) begin
            wd_next = wd_reg + WDW'(1);
            if (wd_reg == WD_LAST) begin
                wd_next        = '0;
                state_next     = IDLE;
                stop_pend_next = 1'b0;
                done_next      = 1'b0;
                ferr_next      = 1'b1;
                cnt_next       = cnt_reg;
            end
        end
`endif
    end

    always_ff @(posedge cmos_pclk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            vs_d1_reg     <= 1'b0;
            href_d1_reg   <= 1'b0;
            href_d2_reg   <= 1'b0;
            skip_cnt_reg  <= '0;
            mode_reg      <= 1'b0;
            stop_pend_reg <= 1'b0;
            err_reg       <= 1'b0;
            x_reg         <= '0;
            y_reg         <= '0;
            base_reg      <= '0;
            valid_reg     <= 1'b0;
            data_reg      <= '0;
            addr_reg      <= '0;
            sof_reg       <= 1'b0;
            eol_reg       <= 1'b0;
            done_reg      <= 1'b0;
            ferr_reg      <= 1'b0;
            cnt_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            vs_d1_reg     <= cmos_vsync;
            href_d1_reg   <= cmos_href;
            href_d2_reg   <= href_d1_reg;
            skip_cnt_reg  <= skip_cnt_next;
            mode_reg      <= mode_next;
            stop_pend_reg <= stop_pend_next;
            err_reg       <= err_next;
            x_reg         <= x_next;
            y_reg         <= y_next;
            base_reg      <= base_next;
            valid_reg     <= valid_next;
            data_reg      <= data_next;
            addr_reg      <= addr_next;
            sof_reg       <= sof_next;
            eol_reg       <= eol_next;
            done_reg      <= done_next;
            ferr_reg      <= ferr_next;
            cnt_reg       <= cnt_next;
        end
    end

`ifdef OV5640_CAP_TIMEOUT_EN
    always_ff @(posedge cmos_pclk or posedge rst) begin
        if (rst) begin
            wd_reg <= '0;
        end else begin
            wd_reg <= wd_next;
        end
    end
`endif

    assign cap_busy          = (state_reg == WAIT_VS) || (state_reg == CAPTURE);
    assign frame_done        = done_reg;
    assign frame_err         = ferr_reg;
    assign frame_cnt         = cnt_reg;
    assign pix_out.out_valid = valid_reg;
    assign pix_out.out_data  = data_reg;
    assign pix_out.out_addr  = addr_reg;
    assign pix_out.out_sof   = sof_reg;
    assign pix_out.out_eol   = eol_reg;

endmodule
